// File: rtl/intr_encoder.sv
// Registered priority interrupt encoder with valid/acknowledge handshake.
// Samples request lines, keeps a pending register (edge bits latched, level
// bits tracking), arbitrates unmasked pending bits and posts the winning
// vector number until the core acknowledges it.
// Ports:
//   iCLK   - clock, rising edge
//   iRSTN  - asynchronous active-low reset
//   iReq   - raw request lines (polarity set by ONE_COLD)
//   iMask  - 1 removes a line from arbitration (pending capture unaffected)
//   iAck   - core acknowledge of the posted vector
//   oValid - a vector is posted
//   oCode  - posted vector number
//   oPend  - pending status
module intr_encoder #(
  parameter int unsigned         SEL_SIZE  = 3,
  parameter int unsigned         OUT_SIZE  = 2**SEL_SIZE,
  parameter bit                  ONE_COLD  = 1'b0,
  parameter logic [OUT_SIZE-1:0] EDGE_MASK = '0,
  parameter bit                  HI_FIRST  = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRSTN,
  input  logic [OUT_SIZE-1:0] iReq,
  input  logic [OUT_SIZE-1:0] iMask,
  input  logic                iAck,
  output logic                oValid,
  output logic [SEL_SIZE-1:0] oCode,
  output logic [OUT_SIZE-1:0] oPend
);

  typedef enum logic [1:0] {IDLE, POST, ACKD} state_e;

  // Raw sample resets to the inactive level so the polarity-corrected view is 0.
  localparam logic [OUT_SIZE-1:0] RawRst = ONE_COLD ? '1 : '0;

  state_e              state_q, state_d;
  logic [OUT_SIZE-1:0] raw_q;
  logic [OUT_SIZE-1:0] req_c;
  logic [OUT_SIZE-1:0] req_dly_q;
  logic [OUT_SIZE-1:0] pend_q, pend_d;
  logic [OUT_SIZE-1:0] clr_c;
  logic [OUT_SIZE-1:0] cand_c;
  logic [SEL_SIZE-1:0] win_c;
  logic                valid_q, valid_d;
  logic [SEL_SIZE-1:0] code_q, code_d;

  assign req_c = ONE_COLD ? ~raw_q : raw_q;

  // Input sample and one-cycle delay for edge detection.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      raw_q     <= RawRst;
      req_dly_q <= '0;
    end else begin
      raw_q     <= iReq;
      req_dly_q <= req_c;
    end
  end

  // Acknowledge clears only the granted bit, and only if it is edge-sensitive.
  assign clr_c = (state_q == POST && iAck) ?
                 ((OUT_SIZE'(1) << code_q) & EDGE_MASK) : '0;

  // Edge bits: new rising edge wins over a same-cycle clear. Level bits follow the sample.
  assign pend_d = (EDGE_MASK & ((req_c & ~req_dly_q) | (pend_q & ~clr_c)))
                | (~EDGE_MASK & req_c);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign cand_c = pend_q & ~iMask;

  // Priority pick: last hit in the scan order wins.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < OUT_SIZE; i++) begin
      if (HI_FIRST) begin
        if (cand_c[i]) win_c = SEL_SIZE'(i);
      end else begin
        if (cand_c[OUT_SIZE-1-i]) win_c = SEL_SIZE'(OUT_SIZE-1-i);
      end
    end
  end

  // FSM state and posted-vector registers.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  // Next-state: post frozen in POST, one dead cycle in ACKD.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (|cand_c) begin
          code_d  = win_c;
          valid_d = 1'b1;
          state_d = POST;
        end
      end
      POST: begin
        if (iAck) begin
          valid_d = 1'b0;
          state_d = ACKD;
        end
      end
      ACKD: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign oValid = valid_q;
  assign oCode  = code_q;
  assign oPend  = pend_q;

endmodule

// File: tb/tb_intr_encoder.sv
// Scoreboard bench for intr_encoder: instance A (active-high, bit 3 level,
// others edge, highest index wins) and instance B (active-low, all level).
module tb_intr_encoder;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic [7:0] req_a, mask_a, req_b, mask_b;
  logic       ack_a, ack_b;
  logic       valid_a, valid_b;
  logic [2:0] code_a, code_b;
  logic [7:0] pend_a, pend_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];

  always #5 clk = ~clk;

  intr_encoder #(.SEL_SIZE(3), .OUT_SIZE(8), .ONE_COLD(1'b0),
                 .EDGE_MASK(8'hF7), .HI_FIRST(1'b1)) u_dut_a (
    .iCLK(clk), .iRSTN(rst_a_n), .iReq(req_a), .iMask(mask_a), .iAck(ack_a),
    .oValid(valid_a), .oCode(code_a), .oPend(pend_a));

  intr_encoder #(.SEL_SIZE(3), .OUT_SIZE(8), .ONE_COLD(1'b1),
                 .EDGE_MASK(8'h00), .HI_FIRST(1'b1)) u_dut_b (
    .iCLK(clk), .iRSTN(rst_b_n), .iReq(req_b), .iMask(mask_b), .iAck(ack_b),
    .oValid(valid_b), .oCode(code_b), .oPend(pend_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor A: pop an expected code on each rising oValid; code must stay frozen while posted.
  logic       prev_a = 1'b0;
  logic [2:0] held_a = '0;
  always @(negedge clk) begin
    if (!rst_a_n) prev_a = 1'b0;
    else begin
      if (valid_a && !prev_a) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL post_a: unexpected post code %0d, expected none", code_a);
        end else chk("post_a", 32'(code_a), 32'(exp_a.pop_front()));
        held_a = code_a;
      end else if (valid_a && prev_a) begin
        chk("frozen_a", 32'(code_a), 32'(held_a));
      end
      prev_a = valid_a;
    end
  end

  // Monitor B: same scheme for the active-low instance.
  logic prev_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_b_n) prev_b = 1'b0;
    else begin
      if (valid_b && !prev_b) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL post_b: unexpected post code %0d, expected none", code_b);
        end else chk("post_b", 32'(code_b), 32'(exp_b.pop_front()));
      end
      prev_b = valid_b;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_post(input string nm, input bit on_b);
    int n = 0;
    while (!(on_b ? valid_b : valid_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no post within 20 cycles, expected oValid=1", nm);
    end
  endtask

  task automatic ack_a_pulse();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_a = '0; mask_a = '0; ack_a = 1'b0;
    req_b = 8'hFF; mask_b = '0; ack_b = 1'b0;

    // Reset: toggling requests has no effect while held.
    for (int i = 0; i < 3; i++) begin
      req_a = (i % 2 == 0) ? 8'hFF : 8'h00;
      req_b = (i % 2 == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      chk("rst_hold_a", {20'd0, valid_a, code_a, pend_a}, 32'd0);
      chk("rst_hold_b", {20'd0, valid_b, code_b, pend_b}, 32'd0);
    end
    req_a = '0; req_b = 8'hFF;
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_release_a", {20'd0, valid_a, code_a, pend_a}, 32'd0);
    end
    chk("rst_release_b", {20'd0, valid_b, code_b, pend_b}, 32'd0);

    // Single edge request on bit 5.
    exp_a.push_back(3'd5);
    req_a = 8'h20;
    @(negedge clk);               // edge T sampled it
    req_a = 8'h00;
    chk("edge_pend_T", 32'(pend_a), 32'h00);
    @(negedge clk);               // after T+1
    chk("edge_pend_T1", 32'(pend_a), 32'h20);
    chk("edge_valid_T1", 32'(valid_a), 32'd0);
    @(negedge clk);               // after T+2: monitor sees post
    chk("edge_valid_T2", 32'(valid_a), 32'd1);
    @(negedge clk);               // after T+3
    ack_a_pulse();                // sampled at T+4
    chk("edge_ack_valid", 32'(valid_a), 32'd0);
    chk("edge_ack_pend", 32'(pend_a), 32'h00);
    tick(2);

    // Priority and mask: bits 2,6,7 rise, bit 7 masked.
    mask_a = 8'h80;
    exp_a.push_back(3'd6);
    exp_a.push_back(3'd2);
    req_a = 8'hC4;
    @(negedge clk);
    req_a = 8'h00;
    wait_post("prio_6", 1'b0);
    ack_a_pulse();
    chk("gap_1", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("gap_2", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("gap_repost", 32'(valid_a), 32'd1);
    ack_a_pulse();
    tick(4);
    chk("masked_idle", 32'(valid_a), 32'd0);
    chk("masked_pend", 32'(pend_a), 32'h80);
    exp_a.push_back(3'd7);
    mask_a = 8'h00;
    wait_post("prio_7", 1'b0);
    ack_a_pulse();
    tick(3);

    // Level source on bit 3: reposted while held, not after it drops.
    exp_a.push_back(3'd3);
    exp_a.push_back(3'd3);
    req_a = 8'h08;
    wait_post("level_first", 1'b0);
    ack_a_pulse();
    chk("level_gap_1", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("level_gap_2", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("level_repost", 32'(valid_a), 32'd1);
    req_a = 8'h00;
    tick(3);
    chk("level_held_valid", 32'(valid_a), 32'd1);
    chk("level_dropped_pend", 32'(pend_a), 32'h00);
    ack_a_pulse();
    for (int i = 0; i < 5; i++) begin
      chk("level_no_repost", 32'(valid_a), 32'd0);
      @(negedge clk);
    end

    // Simultaneous set and clear on edge bit 4.
    exp_a.push_back(3'd4);
    exp_a.push_back(3'd4);
    req_a = 8'h10;
    @(negedge clk);
    req_a = 8'h00;
    wait_post("simul_first", 1'b0);
    req_a = 8'h10;                // sampled one edge before the ack edge
    @(negedge clk);
    req_a = 8'h00;
    ack_a_pulse();                // ack edge sees the new rising edge
    chk("simul_pend", 32'(pend_a), 32'h10);
    chk("simul_valid_low", 32'(valid_a), 32'd0);
    wait_post("simul_repost", 1'b0);
    ack_a_pulse();
    tick(3);
    chk("final_pend_a", 32'(pend_a), 32'h00);
    chk("code_hold_idle", {28'd0, valid_a, code_a}, 32'h4);

    // Active-low instance: 8'hFE asserts line 0.
    exp_b.push_back(3'd0);
    req_b = 8'hFE;
    wait_post("oc_post", 1'b1);
    chk("oc_pend", 32'(pend_b), 32'h01);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("oc_async_valid", 32'(valid_b), 32'd0);
    chk("oc_async_pend", 32'(pend_b), 32'h00);
    req_b = 8'hFF;
    @(negedge clk);
    rst_b_n = 1'b1;
    tick(4);
    chk("oc_after_reset", {20'd0, valid_b, code_b, pend_b}, 32'd0);

    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intr_encoder.md
Name: intr_encoder

Overview:
- Registered priority encoder that turns a vector of interrupt request lines into a binary vector number with a valid/acknowledge handshake. It is the inverse of the binary-to-line decoder.
- Sits between the 8085-style interrupt pins (RST/TRAP-class sources) and the core control unit.
- Captures requests, applies a mask and posts the highest-priority unmasked source.
- Holds the posted vector stable until the core acknowledges it.

Parameters:
- SEL_SIZE, 3: width of the encoded vector number.
- OUT_SIZE, 2**SEL_SIZE: number of request lines.
- ONE_COLD, 0: request polarity. 0 means a line is active high; 1 means a line is active low and is inverted at the input sample.
- EDGE_MASK, {OUT_SIZE{1'b0}}: per-bit sensitivity. 1 means edge-sensitive and latched; 0 means level-sensitive.
- HI_FIRST, 1: priority order. 1 means the highest index wins; 0 means the lowest index wins.

Ports:
- iCLK, input, 1: system clock; all state changes on its rising edge.
- iRSTN, input, 1: reset, asynchronous and active-low.
- iReq, input, OUT_SIZE: raw request lines, synchronous to iCLK.
- iMask, input, OUT_SIZE: 1 masks the corresponding line from arbitration.
- iAck, input, 1: core acknowledge of the posted vector.
- oValid, output, 1: a vector is posted.
- oCode, output, SEL_SIZE: posted vector number.
- oPend, output, OUT_SIZE: pending status, unmasked view.

Behaviour:
- Reset: while iRSTN is low, all registers clear asynchronously.
  - oValid=0, oCode=0, oPend=0, internal sample registers=0 after polarity. With ONE_COLD=1, the raw sample register resets to all-ones.
  - FSM resets to IDLE.
  - Reset mid-POST drops oValid immediately and discards all pending state.
- Input stage:
  - rReq <= iReq (inverted if ONE_COLD).
  - rReqD <= rReq.
- Pending register, updated every cycle:
  - Edge bit: set on rReq & ~rReqD; cleared only by acknowledge of that bit. If set and clear occur in the same cycle, set wins.
  - Level bit: pend <= rReq. It is never latched, and acknowledge has no effect on it.
  - oPend = pend.
- Latency:
  - Request first sampled high at edge T, so pend is set at T+1.
  - If IDLE, oValid=1 with oCode at T+2.
- Arbitration, combinational on pend & ~iMask:
  - HI_FIRST=1 selects the highest set index; HI_FIRST=0 selects the lowest.
  - Masking only affects arbitration, never pend capture.
- FSM:
  - IDLE: if any(pend & ~iMask), load oCode from the arbitration winner, set oValid=1 and go to POST. Otherwise stay.
  - POST: oCode and oValid are frozen.
    - Changes to iMask, new requests, or deassertion of the granted level source do not retract or alter the post.
    - On iAck=1: clear pend[oCode] if that bit is edge-sensitive, set oValid=0 at the same edge, go to ACKD.
  - ACKD: one dead cycle so a level source can deassert, then return to IDLE.
    - iAck is ignored here.
    - Back-to-back posts are therefore spaced by at least 2 cycles of oValid low.
- iAck in IDLE or ACKD is ignored and has no side effects.
- The all-masked or no-request case stays in IDLE with oValid=0 and oCode holding its last value.

Test Plan:
- Reset check:
  - Stimulus: hold iRSTN low, toggle iReq.
  - Required: oValid=0, oCode=0, oPend=0.
  - Stimulus: release iRSTN with iReq=0.
  - Required: outputs unchanged for 5 cycles.
- Single edge request (EDGE_MASK=8'hFF):
  - Stimulus: iReq[5] pulses high for 1 cycle, first sampled at edge T.
  - Required: oPend=8'h20 at T+1; oValid=1, oCode=5 at T+2.
  - Stimulus: iAck at T+4.
  - Required: oValid=0, oPend=0 after T+4.
- Priority and mask (HI_FIRST=1, edge):
  - Stimulus: iReq bits 2, 6 and 7 rise together; iMask=8'h80.
  - Required: code 6 is posted.
  - Stimulus: ack it.
  - Required: code 2 is posted, with oValid low for exactly 2 cycles between posts.
  - Stimulus: set iMask=0 after both acks.
  - Required: code 7 is posted.
- Level source (EDGE_MASK=0):
  - Stimulus: hold iReq[3] high through the ack.
  - Required: code 3 is reposted at ACKD+1.
  - Stimulus: drop iReq[3] during POST.
  - Required: the post is held until ack and is not reposted.
- Simultaneous set and clear:
  - Stimulus: a new rising edge on bit 4 is detected in the same cycle as iAck of code 4.
  - Required: pend[4] stays 1 and code 4 is reposted after ACKD.
- Polarity and reset mid-operation (ONE_COLD=1):
  - Stimulus: iReq=8'hFE.
  - Required: code 0 is posted.
  - Stimulus: assert iRSTN low during POST.
  - Required: oValid drops asynchronously, without waiting for a clock edge.
